// File: rtl/mic_peak_tracker_if.sv
// Sample stream from the mic capture block plus the amplitude outputs
// consumed by the circle visualiser.
interface mic_peak_tracker_if;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [9:0]  wave_sample;
  logic        wave_valid;
  logic [9:0]  peak_raw;

  modport master (
    output sample_valid,
    output mic_in,
    input  wave_sample,
    input  wave_valid,
    input  peak_raw
  );

  modport slave (
    input  sample_valid,
    input  mic_in,
    output wave_sample,
    output wave_valid,
    output peak_raw
  );
endinterface

// File: rtl/mic_peak_tracker.sv
// Windowed peak tracker: turns 12-bit mic samples into a 10-bit amplitude
// level with instant attack and linear per-window decay.
module mic_peak_tracker #(
  parameter int unsigned WINDOW   = 1024,
  parameter int unsigned DECAY    = 8,
  parameter int unsigned MIDSCALE = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  mic_peak_tracker_if.slave bus_io
);

  localparam logic [11:0] MidCode   = 12'(MIDSCALE);
  localparam logic [11:0] MagLimit  = 12'd2047;
  localparam logic [15:0] LastCount = 16'(WINDOW - 1);
  localparam logic [9:0]  DecayStep = 10'(DECAY);

  typedef enum logic {ACCUM, UPDATE} state_t;

  state_t      state_q;
  logic        magValid_q;
  logic [11:0] mag_q;
  logic [11:0] diff_d;
  logic [11:0] mag_d;
  logic [9:0]  mag10_d;
  logic [9:0]  peakMax_d;
  logic [9:0]  waveNext_d;
  logic [15:0] winCount_q;
  logic [9:0]  runPeak_q;
  logic [9:0]  finalPeak_q;
  logic [9:0]  waveSample_q;
  logic [9:0]  peakRaw_q;
  logic        waveValid_q;

  // Magnitude about mid-scale; the single code below zero (2048) clips to 2047
  always_comb begin
    diff_d = '0;
    mag_d  = '0;
    if (bus_io.mic_in >= MidCode) begin
      diff_d = bus_io.mic_in - MidCode;
    end else begin
      diff_d = MidCode - bus_io.mic_in;
    end
    mag_d = (diff_d > MagLimit) ? MagLimit : diff_d;
  end

  // Stage 1: register the magnitude together with its valid bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      magValid_q <= 1'b0;
      mag_q      <= '0;
    end else begin
      magValid_q <= bus_io.sample_valid;
      if (bus_io.sample_valid) begin
        mag_q <= mag_d;
      end
    end
  end

  // Stage 2 scaling to 10 bits, running max, and the attack/decay target
  always_comb begin
    mag10_d    = 10'(mag_q >> 1);
    peakMax_d  = (mag10_d > runPeak_q) ? mag10_d : runPeak_q;
    waveNext_d = finalPeak_q;
    if (finalPeak_q >= waveSample_q) begin
      waveNext_d = finalPeak_q;
    end else if ((waveSample_q - finalPeak_q) > DecayStep) begin
      waveNext_d = waveSample_q - DecayStep;
    end else begin
      waveNext_d = finalPeak_q;
    end
  end

  // Window FSM: accumulate the peak, then publish it for exactly one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      winCount_q   <= '0;
      runPeak_q    <= '0;
      finalPeak_q  <= '0;
      waveSample_q <= '0;
      peakRaw_q    <= '0;
      waveValid_q  <= 1'b0;
    end else begin
      waveValid_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (magValid_q) begin
            if (winCount_q == LastCount) begin
              finalPeak_q <= peakMax_d;
              runPeak_q   <= '0;
              winCount_q  <= '0;
              state_q     <= UPDATE;
            end else begin
              runPeak_q  <= peakMax_d;
              winCount_q <= winCount_q + 16'd1;
            end
          end
        end
        UPDATE: begin
          peakRaw_q    <= finalPeak_q;
          waveSample_q <= waveNext_d;
          waveValid_q  <= 1'b1;
          state_q      <= ACCUM;
          if (magValid_q) begin
            runPeak_q  <= mag10_d;
            winCount_q <= 16'd1;
          end
        end
      endcase
    end
  end

  assign bus_io.wave_sample = waveSample_q;
  assign bus_io.wave_valid  = waveValid_q;
  assign bus_io.peak_raw    = peakRaw_q;

endmodule

// File: doc/mic_peak_tracker.md
Name: mic_peak_tracker

Overview:
- Upstream stage of the circle visualiser: turns raw 12-bit microphone samples into a smoothed 10-bit amplitude level on `wave_sample`, which sets the circle radius.
- Tracks the peak magnitude about mid-scale over a window of samples.
- Publishes that peak with instant attack and linear decay, so the circle jumps out on loud transients and shrinks smoothly afterwards.
- Runs in the pixel/system clock domain; samples arrive as single-cycle strobes from the mic capture block.

Parameters:
- WINDOW, 1024, samples per peak window (2..65535).
- DECAY, 8, level decrement applied per window when the new peak is lower.
- MIDSCALE, 2048, ADC code treated as zero amplitude.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- sample_valid  in  1  single-cycle strobe; mic_in is valid this cycle.
- mic_in  in  12  unsigned ADC sample.
- wave_sample  out  10  smoothed amplitude level, 0..1023.
- wave_valid  out  1  one-cycle pulse when wave_sample updates.
- peak_raw  out  10  unsmoothed peak of the last completed window (debug/LED use).

Behaviour:
- Reset (rst_n=0 at a clock edge) clears all registers: wave_sample=0, wave_valid=0, peak_raw=0, window count=0, running peak=0, FSM=ACCUM.
- A reset mid-window discards the partial window.

Pipeline:
- Stage 1, cycle of sample_valid: mag = |mic_in − MIDSCALE|, 12-bit result, registered with a valid bit.
  - mic_in=0 gives mag=2048, which saturates to 2047.
- Stage 2: mag10 = mag[11:1], i.e. 11→10 bits after saturation.
  - Running peak ← max(running peak, mag10).
  - Window count increments.

FSM:
- ACCUM: stage-2 valid samples are processed as above.
  - When the processed sample is the WINDOW-th, latch final_peak = max(running peak, mag10).
  - Reset running peak to 0 and count to 0, then go to UPDATE.
- UPDATE, exactly 1 cycle:
  - peak_raw ← final_peak.
  - If final_peak ≥ wave_sample, wave_sample ← final_peak.
  - Otherwise wave_sample ← max(wave_sample − DECAY, final_peak); no underflow below final_peak, no wrap below 0.
  - wave_valid=1 for this single cycle.
  - Return to ACCUM.

Latency:
- The last sample's strobe to the wave_valid pulse is 3 clk cycles: stage 1, stage 2, UPDATE.

Simultaneous events:
- A stage-2 sample arriving while in UPDATE must not be lost. It is counted as sample 1 of the new window and seeds running peak = mag10.
- Samples spaced ≥1 cycle apart (back-to-back strobes) must all be counted.

Hold:
- wave_sample and peak_raw hold their values between UPDATE cycles.
- wave_valid is 0 at all other times.

Width rules:
- All subtraction is unsigned, with explicit compare-before-subtract; no negative intermediates.

Test Plan:
1. Reset then silence: WINDOW samples of mic_in=2048 → wave_valid pulses once, wave_sample=0, peak_raw=0, exactly 3 cycles after the 1024th strobe.
2. Full-scale attack: one window containing a single mic_in=4095 sample, all others 2048 → peak_raw=1023 (mag 2047→1023), wave_sample=1023.
3. Decay: after case 2, windows of silence → wave_sample steps 1015, 1007, 999, …
   - Check it never wraps.
   - With a later window peak of 1010 after 1015: max(1007, 1010) → 1010.
4. Low-side magnitude: a window with min sample mic_in=0 → saturation gives peak_raw=1023.
   - mic_in=1024 alone gives peak_raw=512.
5. Back-to-back strobes: sample_valid held high for 2*WINDOW cycles with varying data.
   - Exactly 2 wave_valid pulses.
   - The sample coinciding with UPDATE is counted in window 2, verified by a known peak placed there.
6. Mid-window reset: assert rst_n=0 for 1 cycle after 500 samples containing a peak of 900.
   - All outputs become 0.
   - The next full window reports only its own peak, and its pulse comes after WINDOW post-reset samples.
